key_debounce_pulse: RTL

//  Per-key conditioner for the board push-buttons (KEY[3:0], active-low). Sits between the board pins
//  and Top. For each key: 2-FF synchronizer, saturating debounce counter, and a per-key FSM that emits
//  one-cycle press, release and auto-repeat pulses plus a clean level. Top consumes these outputs

---
 rtl/key_debounce_pulse.sv | 135 +++++++++++++
 1 files changed

// File: rtl/key_debounce_pulse.sv
// Per-key push-button conditioner: 2-FF synchronizer, saturating debounce counter and a
// press/release/auto-repeat pulse FSM per channel, all outputs registered.
module key_debounce_pulse #(
   parameter int NUM_KEYS        = 32'sd4,
   parameter bit ACTIVE_LOW      = 1'b1,
   parameter int DEBOUNCE_CYCLES = 32'sd500000,
   parameter int REPEAT_DELAY    = 32'sd25000000,
   parameter int REPEAT_PERIOD   = 32'sd5000000
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic [NUM_KEYS-1:0] i_key_raw,
   output logic [NUM_KEYS-1:0] o_level,
   output logic [NUM_KEYS-1:0] o_press,
   output logic [NUM_KEYS-1:0] o_release,
   output logic [NUM_KEYS-1:0] o_repeat
);

   localparam int DB_W     = $clog2(DEBOUNCE_CYCLES + 32'sd1);
   localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int HOLD_W   = $clog2(HOLD_MAX + 32'sd1);

   localparam logic [DB_W-1:0]   DB_TERM     = DB_W'(DEBOUNCE_CYCLES - 32'sd1);
   localparam logic [HOLD_W-1:0] DELAY_TERM  = HOLD_W'(REPEAT_DELAY - 32'sd1);
   localparam logic [HOLD_W-1:0] PERIOD_TERM = HOLD_W'(REPEAT_PERIOD - 32'sd1);
   localparam logic              REL_LVL     = ACTIVE_LOW ? 1'b1 : 1'b0;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_WAIT   = 2'd1,
      S_REPEAT = 2'd2
   } key_state_e;

   logic [NUM_KEYS-1:0] sync1_r;
   logic [NUM_KEYS-1:0] sync2_r;
   logic [NUM_KEYS-1:0] key_s;

   // Two-stage synchronizer, preloaded with the released pin level
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sync1_r <= {NUM_KEYS{REL_LVL}};
         sync2_r <= {NUM_KEYS{REL_LVL}};
      end else begin
         sync1_r <= i_key_raw;
         sync2_r <= sync1_r;
      end
   end

   // Normalized key state: 1 = pressed regardless of board polarity
   assign key_s = ACTIVE_LOW ? ~sync2_r : sync2_r;

   for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
      logic [DB_W-1:0]   db_cnt_r;
      logic [HOLD_W-1:0] hold_cnt_r;
      key_state_e        state_r;
      logic              level_r;
      logic              press_r;
      logic              release_r;
      logic              repeat_r;

      // Debounce: a differing level must persist unbroken until the terminal count
      always_ff @(posedge i_clk or negedge i_rst_n) begin
         if (!i_rst_n) begin
            db_cnt_r <= {DB_W{1'b0}};
            level_r  <= 1'b0;
         end else if (key_s[g] == level_r) begin
            db_cnt_r <= {DB_W{1'b0}};
         end else if (db_cnt_r == DB_TERM) begin
            db_cnt_r <= {DB_W{1'b0}};
            level_r  <= key_s[g];
         end else begin
            db_cnt_r <= db_cnt_r + DB_W'(1'b1);
         end
      end

      // Pulse sequencer; a release wins over a repeat terminal in the same cycle
      always_ff @(posedge i_clk or negedge i_rst_n) begin
         if (!i_rst_n) begin
            state_r    <= S_IDLE;
            hold_cnt_r <= {HOLD_W{1'b0}};
            press_r    <= 1'b0;
            release_r  <= 1'b0;
            repeat_r   <= 1'b0;
         end else begin
            press_r   <= 1'b0;
            release_r <= 1'b0;
            repeat_r  <= 1'b0;
            case (state_r)
               S_IDLE: begin
                  hold_cnt_r <= {HOLD_W{1'b0}};
                  if (level_r) begin
                     press_r <= 1'b1;
                     state_r <= S_WAIT;
                  end else begin
                     state_r <= S_IDLE;
                  end
               end
               S_WAIT: begin
                  if (!level_r) begin
                     release_r <= 1'b1;
                     state_r   <= S_IDLE;
                  end else if (hold_cnt_r == DELAY_TERM) begin
                     repeat_r   <= 1'b1;
                     hold_cnt_r <= {HOLD_W{1'b0}};
                     state_r    <= S_REPEAT;
                  end else begin
                     hold_cnt_r <= hold_cnt_r + HOLD_W'(1'b1);
                  end
               end
               S_REPEAT: begin
                  if (!level_r) begin
                     release_r <= 1'b1;
                     state_r   <= S_IDLE;
                  end else if (hold_cnt_r == PERIOD_TERM) begin
                     repeat_r   <= 1'b1;
                     hold_cnt_r <= {HOLD_W{1'b0}};
                  end else begin
                     hold_cnt_r <= hold_cnt_r + HOLD_W'(1'b1);
                  end
               end
               default: begin
                  state_r    <= S_IDLE;
                  hold_cnt_r <= {HOLD_W{1'b0}};
               end
            endcase
         end
      end

      assign o_level[g]   = level_r;
      assign o_press[g]   = press_r;
      assign o_release[g] = release_r;
      assign o_repeat[g]  = repeat_r;
   end

endmodule
